// File: rtl/mux_sel_pipe_if.sv
// Bus bundle for mux_sel_pipe: packed input channels with select, flush, and a
// valid/ready result stream. The block itself connects through the slave modport.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
) ();

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );

endinterface

// File: rtl/mux_sel_pipe.sv
// N-to-1 data selector whose result is held in a registered output stage with a
// one-entry skid buffer, so in_ready never depends combinationally on out_ready.
module mux_sel_pipe #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_IN      = 8,
  parameter int unsigned      SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  mux_sel_pipe_if.slave bus
);

  localparam int unsigned NUM_SLOT = 1 << SEL_W;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  // Bit 0 = main register holds an entry, bit 1 = skid register holds one,
  // so out_valid and in_ready come straight off state flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [WIDTH-1:0] slot [NUM_SLOT];
  logic             accept;
  logic             consume;

  // Unused select codes map to DEFAULT_VAL, so the lookup never indexes past the table.
  for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
    if (k < NUM_IN) begin : g_chan
      assign slot[k] = bus.in_data[k*WIDTH +: WIDTH];
    end else begin : g_dflt
      assign slot[k] = DEFAULT_VAL;
    end
  end

  always_comb begin
    new_entry.data = slot[bus.in_sel];
    new_entry.sel  = bus.in_sel;
    new_entry.err  = (32'(bus.in_sel) >= NUM_IN);
  end

  assign accept  = bus.in_valid && !state_q[1];
  assign consume = state_q[0] && bus.out_ready;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = ST_SKID;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the data registers are reset too, because out_data/out_sel/out_err
  // must read zero after reset, not merely be ignored while out_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = !state_q[1];
  assign bus.out_valid = state_q[0];
  assign bus.out_data  = main_q.data;
  assign bus.out_sel   = main_q.sel;
  assign bus.out_err   = main_q.err;

endmodule
